pair_pattern_tx: RTL and testbench

- Parallel-to-serial pattern transmitter. Drives the single-bit serial line `w` consumed by the team's "two consecutive ones" sequence-detector FSMs.
- Loads a WIDTH-bit word on a start handshake and shifts it out MSB first, one bit per clock.
- Forces `w` low for at least one idle cycle between frames, so a downstream detector returns to its start state.
- Reports how many adjacent "11" pairs the frame contained, i.e. the number of cycles a downstream detector asserts `z` for the frame.

---
 rtl/pair_pattern_tx_if.sv | 24 ++
 rtl/pair_pattern_tx.sv | 95 +++++++++
 tb/tb_pair_pattern_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pair_pattern_tx_if.sv
// Start/data request and serial/status response bundle for pair_pattern_tx.
// The master side issues frames; the slave side is the transmitter.
interface pair_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             w;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pair_cnt;

  modport master (
    output start, data,
    input  w, ready, busy, done, pair_cnt
  );

  modport slave (
    input  start, data,
    output w, ready, busy, done, pair_cnt
  );
endinterface

// File: rtl/pair_pattern_tx.sv
// Parallel-to-serial frame transmitter (MSB first) that also counts adjacent
// 1-1 bit pairs, and guarantees w=0 idle cycles between frames.
module pair_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  pair_pattern_tx_if.slave bus
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             w_q, w_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] pair_q, pair_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      w_q      <= 1'b0;
      prev_q   <= 1'b0;
      pair_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      w_q      <= w_d;
      prev_q   <= prev_d;
      pair_q   <= pair_d;
    end
  end

  // w is registered, so the accept edge already loads the MSB into w_q and the
  // shift register keeps only the bits still to be sent.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    w_d      = 1'b0;
    prev_d   = prev_q;
    pair_d   = pair_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          w_d      = bus.data[WIDTH-1];
          shreg_d  = {bus.data[WIDTH-2:0], 1'b0};
          bitcnt_d = LAST_BIT;
          pair_d   = '0;
          prev_d   = 1'b0;
        end
      end
      SHIFT: begin
        // Score the bit currently on the line against the one before it.
        if (w_q && prev_q) begin
          pair_d = pair_q + CNT_W'(1);
        end
        prev_d = w_q;
        if (bitcnt_q == '0) begin
          state_d = GAP;
        end else begin
          w_d      = shreg_q[WIDTH-1];
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q - BW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.w        = w_q;
  assign bus.busy     = (state_q == SHIFT) || (state_q == GAP);
  assign bus.ready    = !bus.busy;
  assign bus.done     = (state_q == GAP);
  assign bus.pair_cnt = pair_q;

endmodule

// File: tb/tb_pair_pattern_tx.sv
// Scoreboard bench for pair_pattern_tx: stimulus queues expected bits and pair
// counts, a negedge monitor pops and compares them as the DUT emits frames.
module tb_pair_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  pair_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

  pair_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock  (clk),
    .Resetn (Resetn),
    .bus    (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic bit_q[$];
  int   pair_q[$];
  int   last_pair = 0;
  int   last_done_cyc = -1;
  bit   hold_mode = 1'b0;
  bit   prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference two-ones detector: z high in the cycle after two consecutive 1s.
  typedef enum logic [1:0] {D_A, D_B, D_C} det_t;
  det_t det_q;
  int   z_cnt = 0;
  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) det_q <= D_A;
    else if (!bif.w) det_q <= D_A;
    else det_q <= (det_q == D_A) ? D_B : D_C;
  end
  always @(negedge clk) if (Resetn && det_q == D_C) z_cnt++;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (Resetn) begin
      check("ready_xor_busy", int'(bif.ready ^ bif.busy), 1);
      if (prev_done) check("ready_after_done", int'(bif.ready), 1);
      if (bif.ready) begin
        check("idle_w", int'(bif.w), 0);
        check("pair_hold", int'(bif.pair_cnt), last_pair);
      end
      if (bif.busy && !bif.done) begin
        if (bit_q.size() == 0) flag("unexpected_bit");
        else check("w_bit", int'(bif.w), int'(bit_q.pop_front()));
      end
      if (bif.done) begin
        check("gap_w", int'(bif.w), 0);
        check("bits_left_at_done", bit_q.size(), 0);
        if (pair_q.size() == 0) flag("unexpected_done");
        else check("pair_cnt", int'(bif.pair_cnt), pair_q.pop_front());
        last_pair = int'(bif.pair_cnt);
        if (hold_mode && last_done_cyc >= 0) check("done_period", cyc - last_done_cyc, WIDTH + 2);
        last_done_cyc = cyc;
      end
      prev_done = bif.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic push_frame(input logic [WIDTH-1:0] d, input int pairs);
    for (int i = WIDTH - 1; i >= 0; i--) bit_q.push_back(d[i]);
    pair_q.push_back(pairs);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bif.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.ready) flag("timeout_ready");
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(bif.ready && bit_q.size() == 0 && pair_q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag("timeout_idle");
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int pairs);
    wait_ready();
    bif.start = 1'b1;
    bif.data  = d;
    push_frame(d, pairs);
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.data  = '0;
  endtask

  initial begin
    bif.start = 1'b0;
    bif.data  = '0;
    #3;
    check("rst_w", int'(bif.w), 0);
    check("rst_ready", int'(bif.ready), 1);
    check("rst_busy", int'(bif.busy), 0);
    check("rst_done", int'(bif.done), 0);
    check("rst_pair", int'(bif.pair_cnt), 0);
    #14 Resetn = 1'b1;

    send(8'hFF, 7);
    wait_idle();
    send(8'hAA, 0);
    wait_idle();

    z_cnt = 0;
    send(8'hB6, 2);
    wait_idle();
    check("detector_z_cycles", z_cnt, 2);

    // Second request during SHIFT must be dropped.
    send(8'h0F, 3);
    repeat (3) @(posedge clk);
    #1;
    bif.start = 1'b1;
    bif.data  = 8'hFF;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.data  = '0;
    wait_idle();
    repeat (WIDTH + 2) @(negedge clk);

    // Back-to-back frames with start held high.
    hold_mode = 1'b1;
    last_done_cyc = -1;
    bif.data = 8'hC3;
    for (int f = 0; f < 3; f++) begin
      wait_ready();
      bif.start = 1'b1;
      push_frame(8'hC3, 2);
      @(posedge clk);
      #1;
    end
    bif.start = 1'b0;
    wait_idle();
    hold_mode = 1'b0;

    // Asynchronous reset after the 4th bit of 8'hFF.
    send(8'hFF, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    check("arst_w", int'(bif.w), 0);
    check("arst_busy", int'(bif.busy), 0);
    check("arst_done", int'(bif.done), 0);
    check("arst_pair", int'(bif.pair_cnt), 0);
    check("arst_ready", int'(bif.ready), 1);
    bit_q.delete();
    pair_q.delete();
    last_pair = 0;
    @(negedge clk);
    #2 Resetn = 1'b1;

    send(8'h81, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
